// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision helpers for the fixed/screen-to-float stages.
package float_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } fp32_t;

  localparam int unsigned FP32_BIAS = 127;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StDiv,
    StRound,
    StOut
  } state_e;

endpackage

// File: rtl/screen_to_float_map_if.sv
// Input and result handshake bundle for screen_to_float_map.
interface screen_to_float_map_if #(
  parameter int unsigned IN_WIDTH = 32
);
  logic                valid_in;
  logic                ready_out;
  logic [IN_WIDTH-1:0] input_integer;
  logic                data_valid_out;
  logic                data_ready_in;
  logic [31:0]         output_float;
  logic                sat_out;

  modport slave (
    input  valid_in,
    input  input_integer,
    input  data_ready_in,
    output ready_out,
    output data_valid_out,
    output output_float,
    output sat_out
  );

  modport master (
    output valid_in,
    output input_integer,
    output data_ready_in,
    input  ready_out,
    input  data_valid_out,
    input  output_float,
    input  sat_out
  );
endinterface

// File: rtl/restoring_divider.sv
// Iterative restoring divider producing QBITS quotient bits, one per cycle, plus a sticky flag.
module restoring_divider #(
  parameter int unsigned NUM_W = 10,
  parameter int unsigned DEN_W = 10,
  parameter int unsigned QBITS = 25
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [QBITS-1:0] quot_o,
  output logic             sticky_o
);
  localparam int unsigned CW = $clog2(QBITS);

  logic [NUM_W-1:0] rem_q, rem_d, den_ext, rem_sub;
  logic [QBITS-1:0] quot_q, quot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             q_bit;

  assign den_ext = NUM_W'(den_i);
  assign q_bit   = (rem_q >= den_ext);
  assign rem_sub = q_bit ? (rem_q - den_ext) : rem_q;

  // High in the cycle whose closing edge produces the final quotient bit.
  assign done_o   = busy_q && (cnt_q == CW'(QBITS - 1));
  assign quot_o   = quot_q;
  assign sticky_o = |rem_q;

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = num_i;
      quot_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_sub << 1;
      quot_d = {quot_q[QBITS-2:0], q_bit};
      cnt_d  = cnt_q + 1'b1;
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/screen_to_float_map.sv
// Maps an unsigned screen/angle coordinate x in [0, 2*HALF_RANGE] to fp32 (x - HALF_RANGE)/HALF_RANGE.
module screen_to_float_map
  import float_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned HALF_RANGE = 180
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  screen_to_float_map_if.slave  bus
);
  localparam int unsigned RW   = $clog2(2 * HALF_RANGE) + 1;
  localparam int unsigned KMAX = $clog2(HALF_RANGE);
  localparam int unsigned SW   = RW + KMAX;
  localparam logic [IN_WIDTH-1:0] TwoH = IN_WIDTH'(2 * HALF_RANGE);
  localparam logic [IN_WIDTH-1:0] Half = IN_WIDTH'(HALF_RANGE);

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] x_q, x_d;
  logic                sign_q, sign_d;
  logic [7:0]          exp_q, exp_d;
  logic                sat_pend_q, sat_pend_d;
  logic                ready_q, ready_d;
  logic                dv_q, dv_d;
  fp32_t               out_q, out_d;
  logic                sat_q, sat_d;

  logic [IN_WIDTH-1:0] x_clamp, mag;
  logic                sat, neg;
  logic [SW-1:0]       mag_s;
  logic [7:0]          k;
  logic [RW-1:0]       rem_load;
  logic                div_start, div_done, div_sticky;
  logic [24:0]         quot;
  logic                rnd_up;
  logic [24:0]         mant_r;
  fp32_t               res_round;
  logic                unused_mant_msb;

  // PREP datapath: clamp, signed offset, and normalising shift search.
  always_comb begin
    sat     = (x_q > TwoH);
    x_clamp = sat ? TwoH : x_q;
    neg     = (x_clamp < Half);
    mag     = neg ? (Half - x_clamp) : (x_clamp - Half);
    mag_s   = SW'(mag[RW-1:0]);
    k       = '0;
    // Descending scan so the smallest qualifying shift wins.
    for (int i = int'(KMAX); i >= 1; i--) begin
      if ((mag_s << i) >= SW'(HALF_RANGE)) k = 8'(i);
    end
    rem_load = RW'(mag_s << k);
  end

  restoring_divider #(
    .NUM_W (RW),
    .DEN_W (RW),
    .QBITS (25)
  ) u_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start_i  (div_start),
    .num_i    (rem_load),
    .den_i    (RW'(HALF_RANGE)),
    .done_o   (div_done),
    .quot_o   (quot),
    .sticky_o (div_sticky)
  );

  // Round-to-nearest-even on the 24-bit mantissa with guard bit and remainder sticky.
  always_comb begin
    rnd_up          = quot[0] && (div_sticky || quot[1]);
    mant_r          = {1'b0, quot[24:1]} + 25'(rnd_up);
    res_round.sign  = sign_q;
    res_round.exp   = exp_q + 8'(mant_r[24]);
    res_round.mant  = mant_r[22:0];
    unused_mant_msb = mant_r[23];
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sat_pend_d = sat_pend_q;
    ready_d    = ready_q;
    dv_d       = dv_q;
    out_d      = out_q;
    sat_d      = sat_q;
    div_start  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          x_d     = bus.input_integer;
          ready_d = 1'b0;
          state_d = StPrep;
        end
      end
      StPrep: begin
        sat_pend_d = sat;
        sign_d     = neg;
        if (mag == '0) begin
          out_d   = FP32_ZERO;
          sat_d   = sat;
          dv_d    = 1'b1;
          state_d = StOut;
        end else if (mag == Half) begin
          out_d   = {neg, FP32_ONE[30:0]};
          sat_d   = sat;
          dv_d    = 1'b1;
          state_d = StOut;
        end else begin
          exp_d     = 8'(FP32_BIAS) - k;
          div_start = 1'b1;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (div_done) state_d = StRound;
      end
      StRound: begin
        out_d   = res_round;
        sat_d   = sat_pend_q;
        dv_d    = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        if (bus.data_ready_in) begin
          dv_d    = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        ready_d = 1'b1;
        dv_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      x_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sat_pend_q <= 1'b0;
      ready_q    <= 1'b1;
      dv_q       <= 1'b0;
      out_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sat_pend_q <= sat_pend_d;
      ready_q    <= ready_d;
      dv_q       <= dv_d;
      out_q      <= out_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.ready_out      = ready_q;
  assign bus.data_valid_out = dv_q;
  assign bus.output_float   = out_q;
  assign bus.sat_out        = sat_q;

endmodule

// File: tb/tb_screen_to_float_map.sv
// Directed and sweep checks for screen_to_float_map with HALF_RANGE=180.
module tb_screen_to_float_map;

  localparam int unsigned HALF = 180;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  screen_to_float_map_if #(.IN_WIDTH(32)) bus ();

  screen_to_float_map #(
    .IN_WIDTH   (32),
    .HALF_RANGE (HALF)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Independent model: scale to a 24-bit integer quotient, then RNE on the exact remainder.
  function automatic logic [31:0] ref_float(input int unsigned x);
    int unsigned     xc;
    longint unsigned mag, num, q, r;
    int              s;
    logic            sgn;
    xc  = (x > 2 * HALF) ? 2 * HALF : x;
    sgn = (xc < HALF);
    mag = sgn ? longint'(HALF - xc) : longint'(xc - HALF);
    if (mag == 0) return 32'h0;
    s = 0;
    while (((mag << s) / HALF) < 64'd8388608) s++;
    num = mag << s;
    q   = num / HALF;
    r   = num % HALF;
    if ((2 * r > HALF) || ((2 * r == HALF) && q[0])) q++;
    if (q == 64'd16777216) begin
      q = 64'd8388608;
      s--;
    end
    return {sgn, 8'(150 - s), q[22:0]};
  endfunction

  task automatic start_txn(input logic [31:0] v, output logic [31:0] f, output logic s,
                           output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.valid_in      = 1'b1;
    bus.input_integer = v;
    while (bus.ready_out !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    lat = 0;
    while (bus.data_valid_out !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) check("dv_timeout", 32'(bus.data_valid_out), 32'd1);
    f = bus.output_float;
    s = bus.sat_out;
  endtask

  task automatic finish_txn();
    bus.data_ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.data_ready_in = 1'b0;
  endtask

  logic [31:0] vals [9] = '{32'd180, 32'd0, 32'd360, 32'd270, 32'd225, 32'd135,
                            32'd240, 32'd120, 32'd181};
  logic [31:0] exps [9] = '{32'h0000_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h3F00_0000,
                            32'h3E80_0000, 32'hBE80_0000, 32'h3EAA_AAAB, 32'hBEAA_AAAB,
                            32'h3BB6_0B61};
  int          lats [9] = '{1, 1, 1, 27, 27, 27, 27, 27, 27};

  logic [31:0] f;
  logic        s;
  int          lat;

  initial begin
    bus.valid_in      = 1'b0;
    bus.input_integer = '0;
    bus.data_ready_in = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready_out), 32'd1);
    check("rst_dv", 32'(bus.data_valid_out), 32'd0);
    check("rst_float", bus.output_float, 32'h0);
    check("rst_sat", 32'(bus.sat_out), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", 32'(bus.ready_out), 32'd1);
    check("idle_dv", 32'(bus.data_valid_out), 32'd0);

    for (int i = 0; i < 9; i++) begin
      start_txn(vals[i], f, s, lat);
      check($sformatf("dir_val_%0d", vals[i]), f, exps[i]);
      check($sformatf("dir_sat_%0d", vals[i]), 32'(s), 32'd0);
      check($sformatf("dir_lat_%0d", vals[i]), 32'(lat), 32'(lats[i]));
      finish_txn();
      check($sformatf("dir_ready_%0d", vals[i]), 32'(bus.ready_out), 32'd1);
    end

    for (int x = 0; x <= 2 * HALF; x++) begin
      start_txn(32'(x), f, s, lat);
      check($sformatf("sweep_%0d", x), f, ref_float(x));
      finish_txn();
    end

    // Clamped input, then hold off the consumer while poking valid_in.
    start_txn(32'd500, f, s, lat);
    check("sat_val", f, 32'h3F80_0000);
    check("sat_flag", 32'(s), 32'd1);
    check("sat_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.valid_in      = (i == 3);
      bus.input_integer = 32'd270;
      @(posedge clk);
      #1;
      check($sformatf("stall_val_%0d", i), bus.output_float, 32'h3F80_0000);
      check($sformatf("stall_dv_%0d", i), 32'(bus.data_valid_out), 32'd1);
      check($sformatf("stall_ready_%0d", i), 32'(bus.ready_out), 32'd0);
    end
    bus.valid_in = 1'b0;
    check("stall_sat", 32'(bus.sat_out), 32'd1);
    finish_txn();
    check("post_stall_dv", 32'(bus.data_valid_out), 32'd0);
    @(posedge clk);
    #1;
    check("post_stall_ready", 32'(bus.ready_out), 32'd1);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    bus.valid_in      = 1'b1;
    bus.input_integer = 32'd270;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(bus.ready_out), 32'd1);
    check("arst_dv", 32'(bus.data_valid_out), 32'd0);
    check("arst_float", bus.output_float, 32'h0);
    check("arst_sat", 32'(bus.sat_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_txn(32'd270, f, s, lat);
    check("after_rst_val", f, 32'h3F00_0000);
    check("after_rst_lat", 32'(lat), 32'd27);
    finish_txn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
